// File: rtl/thread_sequencer_if.sv
// Router requester port and result-memory write port of one thread_sequencer.
// master = sequencer side, slave = router / result memory side.
interface thread_sequencer_if #(
  parameter int IW = 32,
  parameter int RW = 32,
  parameter int AW = 4
);
  logic [IW-1:0] dp_instruction;
  logic          dp_start;
  logic [RW-1:0] dp_result;
  logic          dp_finished;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_data;

  modport master (
    output dp_instruction, dp_start, res_we, res_addr, res_data,
    input  dp_result, dp_finished
  );

  modport slave (
    input  dp_instruction, dp_start, res_we, res_addr, res_data,
    output dp_result, dp_finished
  );
endinterface

// File: rtl/thread_sequencer.sv
// Per-thread program sequencer driving one router requester port; results go to result memory.
// Optional WAIT watchdog enabled by defining SEQ_TIMEOUT_EN.
module thread_sequencer #(
  parameter int IW      = 32,
  parameter int RW      = 32,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [IW-1:0]      prog_data,
  input  logic               run,
  input  logic [AW:0]        len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  thread_sequencer_if.master rp
);
  // state | meaning
  // IDLE  | program loadable, waiting for run while router reports finished
  // ISSUE | dp_start high, instruction prog[pc] presented
  // GUARD | router still clearing finished; ignore it
  // WAIT  | waiting for dp_finished (or watchdog)
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  state_t        state, state_nxt;
  logic [IW-1:0] prog [DEPTH];
  logic [AW-1:0] pc, pc_nxt;
  logic [AW:0]   cnt, cnt_nxt, len_clamp;
  logic          accept, finish, tmo, tmo_hit, last;
  logic          busy_nxt, done_nxt;
  logic          dp_start_q, dp_start_nxt;
  logic [IW-1:0] dp_instr_q, dp_instr_nxt, prog_rd;
  logic          res_we_q, res_we_nxt;
  logic [AW-1:0] res_addr_q, res_addr_nxt;
  logic [RW-1:0] res_data_q, res_data_nxt;

  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign last      = ({1'b0, pc} == (cnt - 1'b1));

  always_ff @(posedge clock) begin
    if (prog_we && state == S_IDLE) prog[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pc         <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dp_start_q <= 1'b0;
      dp_instr_q <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      dp_start_q <= dp_start_nxt;
      dp_instr_q <= dp_instr_nxt;
      res_we_q   <= res_we_nxt;
      res_addr_q <= res_addr_nxt;
      res_data_q <= res_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && rp.dp_finished) begin
          accept    = 1'b1;
          pc_nxt    = '0;
          cnt_nxt   = len_clamp;
          state_nxt = (len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_GUARD;
      S_GUARD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (rp.dp_finished) begin
          finish = 1'b1;
          if (last) begin
            state_nxt = S_DONE;
          end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = S_ISSUE;
          end
        end else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort outranks a same-cycle finish; the in-flight result is dropped
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      pc_nxt    = pc;
      finish    = 1'b0;
      tmo       = 1'b0;
    end
  end

  always_comb begin
    // a same-cycle program write to the first slot must be what gets issued
    prog_rd      = (prog_we && state == S_IDLE && prog_addr == pc_nxt) ? prog_data : prog[pc_nxt];
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = (state_nxt == S_DONE);
    dp_start_nxt = (state_nxt == S_ISSUE);
    dp_instr_nxt = dp_start_nxt ? prog_rd : dp_instr_q;
    res_we_nxt   = finish;
    res_addr_nxt = finish ? pc : res_addr_q;
    res_data_nxt = finish ? rp.dp_result : res_data_q;
  end

  assign rp.dp_start       = dp_start_q;
  assign rp.dp_instruction = dp_instr_q;
  assign rp.res_we         = res_we_q;
  assign rp.res_addr       = res_addr_q;
  assign rp.res_data       = res_data_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] wait_cnt;
  logic          timeout_err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (accept)   timeout_err_q <= 1'b0;
      else if (tmo) timeout_err_q <= 1'b1;
    end
  end

  // wait_cnt holds the WAIT cycles already elapsed, so this is the TIMEOUT-th one
  assign tmo_hit     = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = (TIMEOUT == 0) | tmo | accept;
`endif
endmodule

// File: tb/tb_thread_sequencer.sv
// Randomized self-checking bench for thread_sequencer with a behavioural router model
// and a program-level reference (expected writes = prog[i]+1 for i < min(len, DEPTH)).
module tb_thread_sequencer;
  localparam int IW = 32, RW = 32, DEPTH = 16, AW = 4, TOUT = 10;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          run = 1'b0;
  logic [AW:0]   len = '0;
  logic          abort = 1'b0;
  logic          busy, done, timeout_err;

  thread_sequencer_if #(.IW(IW), .RW(RW), .AW(AW)) rp ();

  thread_sequencer #(.IW(IW), .RW(RW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TOUT)) dut (
    .clock(clock), .resetn(resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .len(len), .abort(abort), .busy(busy),
    .done(done), .timeout_err(timeout_err), .rp(rp)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  logic [IW-1:0] prog_m [DEPTH];

  // router model: clears finished on start, completes after a random latency unless held
  int rt_starts = 0, rt_hold_after = 1000000, rt_lat_min = 1, rt_lat_max = 4, rt_cnt = 0;
  logic [IW-1:0] rt_instr = '0;
  initial begin
    rp.dp_finished = 1'b1;
    rp.dp_result   = '0;
  end
  always @(negedge clock) begin
    if (rp.dp_start) begin
      rp.dp_finished = 1'b0;
      rt_instr       = rp.dp_instruction;
      rt_cnt         = int'($urandom_range(rt_lat_max, rt_lat_min));
      rt_starts++;
    end else if (!rp.dp_finished && rt_starts <= rt_hold_after) begin
      if (rt_cnt <= 1) begin
        rp.dp_finished = 1'b1;
        rp.dp_result   = rt_instr + 32'd1;
      end else rt_cnt--;
    end
  end

  always @(posedge clock) cyc++;

  logic [AW-1:0] wr_a_q [$];
  logic [RW-1:0] wr_d_q [$];
  logic [IW-1:0] iss_q [$];
  int done_cnt = 0, done_cyc = -1, last_we_cyc = -1, run_cyc = 0;
  always @(negedge clock) begin
    if (rp.res_we) begin
      wr_a_q.push_back(rp.res_addr);
      wr_d_q.push_back(rp.res_data);
      last_we_cyc = cyc;
    end
    if (rp.dp_start) iss_q.push_back(rp.dp_instruction);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon;
    wr_a_q.delete(); wr_d_q.delete(); iss_q.delete();
    done_cnt = 0; done_cyc = -1; last_we_cyc = -1;
  endtask

  task automatic load_prog(input int a, input logic [IW-1:0] d);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
    prog_m[a] = d;
  endtask

  task automatic start_run(input int l);
    @(negedge clock);
    run = 1'b1; len = (AW+1)'(l);
    @(posedge clock); #1;
    run = 1'b0; run_cyc = cyc;
  endtask

  task automatic wait_fin(output bit ok);
    for (int i = 0; i < 200 && !rp.dp_finished; i++) begin @(posedge clock); #1; end
    ok = rp.dp_finished;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clock); #1;
      if (done) ok = 1'b1;
    end
  endtask

  // run a program of length l and compare every write/issue against the reference
  task automatic test_run(input int l);
    int n; bit ok;
    n = (l > DEPTH) ? DEPTH : l;
    wait_fin(ok);
    checks++; if (!ok) begin errors++; $display("FAIL run_fin_wait: finished=%0b want 1", rp.dp_finished); end
    clear_mon();
    start_run(l);
    if (n > 0) begin
      checks++;
      if (rp.dp_start !== 1'b1 || busy !== 1'b1 || rp.dp_instruction !== prog_m[0]) begin
        errors++; $display("FAIL run_first_issue len=%0d: start=%0b busy=%0b instr=%0h want 1 1 %0h", l, rp.dp_start, busy, rp.dp_instruction, prog_m[0]);
      end
      wait_done(400, ok);
    end else begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || rp.dp_start !== 1'b0) begin
        errors++; $display("FAIL run_empty_t1: done=%0b busy=%0b start=%0b want 1 1 0", done, busy, rp.dp_start);
      end
      ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL run_done_timeout len=%0d: no done within budget", l); end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL run_after_done len=%0d: busy=%0b done=%0b want 0 0", l, busy, done);
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL run_done_count len=%0d: got %0d want 1", l, done_cnt); end
    checks++;
    if (wr_a_q.size() != n || iss_q.size() != n) begin
      errors++; $display("FAIL run_counts len=%0d: writes=%0d issues=%0d want %0d", l, wr_a_q.size(), iss_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wr_a_q[i] !== AW'(i) || wr_d_q[i] !== prog_m[i] + 32'd1 || iss_q[i] !== prog_m[i]) begin
          errors++; $display("FAIL run_entry %0d: addr=%0d data=%0h instr=%0h want %0d %0h %0h", i, wr_a_q[i], wr_d_q[i], iss_q[i], i, prog_m[i] + 32'd1, prog_m[i]);
        end
      end
    end
    if (n > 0) begin
      checks++;
      if (done_cyc !== last_we_cyc) begin errors++; $display("FAIL run_done_align: done cyc %0d want %0d", done_cyc, last_we_cyc); end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, timeout_err, rp.dp_start, rp.res_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %05b want 00000", {busy, done, timeout_err, rp.dp_start, rp.res_we});
    end
    checks++;
    if (rp.dp_instruction !== '0 || rp.res_addr !== '0 || rp.res_data !== '0) begin
      errors++; $display("FAIL reset_buses: instr=%0h addr=%0h data=%0h want 0", rp.dp_instruction, rp.res_addr, rp.res_data);
    end
  endtask

  task automatic test_single;
    load_prog(0, 32'h11); load_prog(1, 32'h22); load_prog(2, 32'h33);
    rt_lat_min = 2; rt_lat_max = 2;
    test_run(3);
    checks++;
    if (wr_d_q.size() != 3 || wr_d_q[0] !== 32'h12 || wr_d_q[1] !== 32'h23 || wr_d_q[2] !== 32'h34) begin
      errors++; $display("FAIL single_results: got %0d entries, first %0h want 12 23 34", wr_d_q.size(), wr_d_q[0]);
    end
    rt_lat_min = 1; rt_lat_max = 4;
  endtask

  task automatic test_empty;
    test_run(0);
  endtask

  task automatic test_write_run;
    bit ok; logic [IW-1:0] d;
    d = $urandom;
    wait_fin(ok);
    clear_mon();
    @(negedge clock);
    prog_we = 1'b1; prog_addr = '0; prog_data = d; run = 1'b1; len = 1;
    @(posedge clock); #1;
    prog_we = 1'b0; run = 1'b0; prog_m[0] = d;
    checks++;
    if (rp.dp_start !== 1'b1 || rp.dp_instruction !== d) begin
      errors++; $display("FAIL write_run_issue: start=%0b instr=%0h want 1 %0h", rp.dp_start, rp.dp_instruction, d);
    end
    wait_done(50, ok);
    @(posedge clock); #1;
    checks++;
    if (!ok || wr_d_q.size() != 1 || wr_d_q[0] !== d + 32'd1) begin
      errors++; $display("FAIL write_run_result: done=%0b writes=%0d data=%0h want 1 1 %0h", ok, wr_d_q.size(), wr_d_q[0], d + 32'd1);
    end
  endtask

  task automatic test_busy_write;
    bit ok;
    load_prog(0, 32'h11); load_prog(1, 32'h22); load_prog(2, 32'h33);
    wait_fin(ok);
    clear_mon();
    start_run(3);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = '0; prog_data = 32'hFF;
    @(posedge clock); #1;
    prog_we = 1'b0;
    wait_done(100, ok);
    @(posedge clock); #1;
    checks++;
    if (!ok || wr_d_q.size() != 3) begin errors++; $display("FAIL busy_write_run: done=%0b writes=%0d want 1 3", ok, wr_d_q.size()); end
    test_run(1);
    checks++;
    if (iss_q.size() != 1 || iss_q[0] !== 32'h11) begin
      errors++; $display("FAIL busy_write_ignored: issued %0h want 11", iss_q[0]);
    end
  endtask

  task automatic test_random;
    int lens [4] = '{16, 17, 31, 1};
    int l;
    for (int it = 0; it < 24; it++) begin
      for (int s = 0; s < DEPTH; s++)
        if (it == 0 || $urandom_range(1, 0) == 1) load_prog(s, $urandom);
      rt_lat_min = 1;
      rt_lat_max = int'($urandom_range(4, 1));
      l = (it < 4) ? lens[it] : int'($urandom_range(31, 0));
      test_run(l);
    end
    rt_lat_max = 4;
  endtask

  task automatic test_abort;
    bit ok, seen;
    int i;
    for (i = 0; i < 4; i++) load_prog(i, $urandom);
    wait_fin(ok);
    clear_mon();
    rt_hold_after = rt_starts + 1;
    start_run(4);
    for (i = 0; i < 100 && iss_q.size() < 2; i++) begin @(posedge clock); #1; end
    checks++; if (iss_q.size() != 2) begin errors++; $display("FAIL abort_reach_wait: issues=%0d want 2", iss_q.size()); end
    repeat (3) @(posedge clock);
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rp.dp_start !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%0b start=%0b done=%0b want 0 0 0", busy, rp.dp_start, done);
    end
    @(negedge clock); run = 1'b1; len = 1;
    seen = 1'b0;
    for (i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (busy || rp.dp_start || done || rp.res_we) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_holdoff: activity seen=1 want 0"); end
    checks++;
    if (wr_a_q.size() != 1 || done_cnt != 0) begin
      errors++; $display("FAIL abort_no_result: writes=%0d done=%0d want 1 0", wr_a_q.size(), done_cnt);
    end
    rt_hold_after = 1000000;
    seen = 1'b0;
    for (i = 0; i < 20 && !seen; i++) begin @(posedge clock); #1; if (rp.dp_start) seen = 1'b1; end
    run = 1'b0;
    checks++;
    if (!seen || rp.dp_instruction !== prog_m[0]) begin
      errors++; $display("FAIL abort_rerun: start=%0b instr=%0h want 1 %0h", seen, rp.dp_instruction, prog_m[0]);
    end
    wait_done(50, ok);
    @(posedge clock); #1;
    checks++;
    if (!ok || wr_a_q.size() != 2 || wr_a_q[1] !== '0 || wr_d_q[1] !== prog_m[0] + 32'd1) begin
      errors++; $display("FAIL abort_rerun_result: writes=%0d data=%0h want 2 %0h", wr_a_q.size(), wr_d_q[1], prog_m[0] + 32'd1);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    load_prog(0, 32'h11); load_prog(1, 32'h22); load_prog(2, 32'h33);
    wait_fin(ok);
    clear_mon();
    start_run(3);
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({busy, done, timeout_err, rp.dp_start, rp.res_we} !== 5'b0 || rp.dp_instruction !== '0 ||
        rp.res_addr !== '0 || rp.res_data !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: flags=%05b instr=%0h want 0", {busy, done, timeout_err, rp.dp_start, rp.res_we}, rp.dp_instruction);
    end
    resetn = 1'b1;
    test_run(3);
  endtask

  task automatic test_timeout;
    bit ok, seen;
    wait_fin(ok);
    clear_mon();
    rt_hold_after = rt_starts;
`ifdef SEQ_TIMEOUT_EN
    start_run(2);
    wait_done(100, ok);
    checks++;
    if (!ok || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: done=%0b err=%0b want 1 1", ok, timeout_err); end
    @(posedge clock); #1;
    checks++;
    if (done_cyc != run_cyc + TOUT + 2) begin errors++; $display("FAIL timeout_cycles: done at %0d want %0d", done_cyc, run_cyc + TOUT + 2); end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || wr_a_q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL timeout_after: busy=%0b err=%0b writes=%0d done=%0d want 0 1 0 1", busy, timeout_err, wr_a_q.size(), done_cnt);
    end
    rt_hold_after = 1000000;
    wait_fin(ok);
    clear_mon();
    start_run(1);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: err=%0b want 0", timeout_err); end
    wait_done(50, ok);
    @(posedge clock); #1;
`else
    start_run(1);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin @(posedge clock); #1; if (!busy) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL no_timeout_busy: busy dropped want held 1000 cycles"); end
    checks++;
    if (timeout_err !== 1'b0 || wr_a_q.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL no_timeout_quiet: err=%0b writes=%0d done=%0d want 0 0 0", timeout_err, wr_a_q.size(), done_cnt);
    end
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_timeout_abort: busy=%0b want 0", busy); end
    rt_hold_after = 1000000;
    wait_fin(ok);
`endif
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    resetn = 1'b1;
    test_single();
    test_empty();
    test_write_run();
    test_busy_write();
    test_random();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
